dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  Bus initiator for the word-addressed data memory port (rd/wr/addr/wdata/rdata).
//  Copies a block of LEN 32-bit words from SRC to DST by alternating read and write cycles.
//  Sits beside the CPU and drives the data memory port when granted.
//  Offloads block moves, e.g. stack/frame copies, from the CPU.
// PARAMETERS
//  LEN_W      8    width of the length port; max block = 2**LEN_W-1 words
//  WORD_BYTES 4    address increment per word; addresses must be multiples of this
// PORTS
//  clk        in   1      system clock; all state updates on posedge
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request pulse; sampled only in IDLE
//  src_addr   in   32     byte address of the first source word
//  dst_addr   in   32     byte address of the first destination word
//  len        in   LEN_W  number of words to copy
//  busy       out  1      high from the cycle after start is accepted until the DONE cycle, inclusive
//  done       out  1      one-cycle pulse when the copy completes (also when len==0)
//  err        out  1      one-cycle pulse when start is rejected for misalignment
//  mem_rd     out  1      memory read strobe; rdata is combinational and valid in the same cycle
//  mem_wr     out  1      memory write strobe; memory commits wdata at the next posedge
//  mem_addr   out  32     byte address to memory
//  mem_wdata  out  32     write data to memory
//  mem_rdata  in   32     read data from memory
// BEHAVIOUR
//  Reset
//   - State goes to IDLE.
//   - busy, done, err, mem_rd, mem_wr are 0; mem_addr and mem_wdata are 0.
//   - Internal counters and the data buffer are cleared.
//   - mem_rd/mem_wr are gated by !reset, so reset mid-copy issues no further access.
//   - Words already written stay written; there is no rollback.
//  FSM states: IDLE -> READ -> WRITE -> (READ | DONE) -> IDLE; error path IDLE -> ERR -> IDLE.
//   - IDLE, start=1, src[1:0] or dst[1:0] != 0: go to ERR (err=1 for one cycle, no access), then IDLE.
//   - IDLE, start=1, aligned, len==0: go to DONE with no memory access.
//   - IDLE, start=1, aligned, len!=0: latch src, dst and count=len, then go to READ.
//   - READ:  mem_rd=1, mem_addr=src. Capture mem_rdata into buf at the edge. Go to WRITE.
//   - WRITE: mem_wr=1, mem_addr=dst, mem_wdata=buf. Then src+=4, dst+=4, count-=1.
//            If count was 1, go to DONE; otherwise go to READ.
//   - DONE:  done=1 for one cycle, then IDLE.
//  Timing
//   - Each word takes exactly 2 cycles; the copy is ascending-address.
//   - start at cycle 0 -> first READ at cycle 1 -> done high at cycle 2*len+1.
//   - mem_rd and mem_wr are never high in the same cycle.
//   - Both are 0 in IDLE, DONE and ERR; mem_addr and mem_wdata are 0 when no strobe is active.
//  Boundaries
//   - start while busy is ignored; it is neither queued nor flagged.
//   - Address increment wraps modulo 2**32.
//   - Overlapping ranges are copied in strict ascending order with no overlap fix-up.
//     dst>src with overlap therefore propagates data; this is defined behaviour.
//   - len is sampled only at accept; later changes to len have no effect.
// CONFIGURATION
//  DMA_CHECKSUM_EN defined
//   - Adds output port checksum (32 bits).
//   - Cleared to 0 on reset and on start accept.
//   - Adds buf in each WRITE cycle, mod 2**32.
//   - Stable from the DONE cycle until the next accept; 0 for len==0.
//  DMA_CHECKSUM_EN undefined
//   - The checksum port and its adder are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package dma_pkg holds:
//   - state encoding localparams (S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR)
//   - WORD_BYTES
//   - the alignment mask 2'b00
//  No sub-module: FSM, counters and buf stay in one module. The memory itself stays outside.
// TESTING (bench uses a 256-word behavioural memory with combinational read)
//  1. Preload mem[0x00..0x0C]=1,2,3,4; start src=0x00 dst=0x40 len=4
//     -> mem[0x40..0x4C]=1,2,3,4; done at cycle 9; 8 strobes alternating rd,wr.
//  2. start len=0 -> done at cycle 1, busy low throughout, no mem_rd/mem_wr.
//  3. start src=0x02 dst=0x40 len=2 -> err pulse at cycle 1, no access, done never high.
//  4. Assert reset during the WRITE of word 2 of a len=4 copy
//     -> only word 1 written, all outputs 0 next cycle, IDLE.
//  5. Overlap: mem[0..3]=A,B,C,D; src=0x00 dst=0x04 len=3 -> mem[1..3]=A,A,A.
//  6. DMA_CHECKSUM_EN: copy 0xFFFFFFFF,0x2 -> checksum=0x00000001 at done;
//     start pulsed while busy has no effect.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA block-copy engine: FSM state encoding,
// word stride and the address alignment pattern.
package dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [1:0]  ALIGN_MASK = 2'b00;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-by-word block copier driving the data memory port (read, then write, per word).
// Optional DMA_CHECKSUM_EN adds a running 32-bit sum of the words written.
module dma_copy_engine
   import dma_pkg::*;
#(
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned WORD_BYTES = dma_pkg::WORD_BYTES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
`ifdef DMA_CHECKSUM_EN
   output logic [31:0]      checksum,
`endif
   input  logic [31:0]      mem_rdata
);

   state_e             state_q, state_d;
   logic [31:0]        src_q, src_d;
   logic [31:0]        dst_q, dst_d;
   logic [LEN_W-1:0]   count_q, count_d;
   logic [31:0]        buf_q, buf_d;
   logic               zero_len_q, zero_len_d;
`ifdef DMA_CHECKSUM_EN
   logic [31:0]        checksum_q, checksum_d;
`endif

   logic misaligned;
   assign misaligned = (src_addr[1:0] != ALIGN_MASK) || (dst_addr[1:0] != ALIGN_MASK);

   // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      count_d    = count_q;
      buf_d      = buf_q;
      zero_len_d = zero_len_q;
`ifdef DMA_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (misaligned) begin
                  state_d = S_ERR;
               end else begin
`ifdef DMA_CHECKSUM_EN
                  checksum_d = 32'h0;
`endif
                  if (len == '0) begin
                     zero_len_d = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     zero_len_d = 1'b0;
                     src_d      = src_addr;
                     dst_d      = dst_addr;
                     count_d    = len;
                     state_d    = S_READ;
                  end
               end
            end
         end
         S_READ: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = src_q;
            buf_d    = mem_rdata;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = buf_q;
            src_d     = src_q + 32'(WORD_BYTES);
            dst_d     = dst_q + 32'(WORD_BYTES);
            count_d   = count_q - LEN_W'(1);
`ifdef DMA_CHECKSUM_EN
            checksum_d = checksum_q + buf_q;
`endif
            state_d   = (count_q == LEN_W'(1)) ? S_DONE : S_READ;
         end
         S_DONE: begin
            // A zero-length request never counts as busy.
            busy    = !zero_len_q;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset silences the port in the same cycle so no access escapes a mid-copy reset.
      if (reset) begin
         busy      = 1'b0;
         done      = 1'b0;
         err       = 1'b0;
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         mem_addr  = 32'h0;
         mem_wdata = 32'h0;
      end
   end

`ifdef DMA_CHECKSUM_EN
   assign checksum = reset ? 32'h0 : checksum_q;
`endif

   // NOTE: state uses non-blocking assignments and a synchronous reset sampled at the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         src_q      <= 32'h0;
         dst_q      <= 32'h0;
         count_q    <= '0;
         buf_q      <= 32'h0;
         zero_len_q <= 1'b0;
`ifdef DMA_CHECKSUM_EN
         checksum_q <= 32'h0;
`endif
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         count_q    <= count_d;
         buf_q      <= buf_d;
         zero_len_q <= zero_len_d;
`ifdef DMA_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: a 256-word memory, a per-cycle
// expected-transaction model, directed scenarios and randomized copies.
module tb_dma_copy_engine;

   localparam int LEN_W  = 8;
   localparam int MAXLEN = 24;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [31:0]      src_addr, dst_addr;
   logic [LEN_W-1:0] len;
   logic             busy, done, err, mem_rd, mem_wr;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;
`ifdef DMA_CHECKSUM_EN
   logic [31:0]      checksum;
`endif

   always #5 clk = ~clk;

   dma_copy_engine #(.LEN_W(LEN_W), .WORD_BYTES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
`ifdef DMA_CHECKSUM_EN
      .checksum  (checksum),
`endif
      .mem_rdata (mem_rdata)
   );

   // Memory under test and the model's view of what it must contain.
   logic [31:0] mem    [256];
   logic [31:0] refmem [256];

   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected bus transactions, one entry per cycle after an accepted start.
   typedef enum {K_IDLE, K_READ, K_WRITE, K_DONE, K_ERR} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] addr;
      logic        busy;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model_buf = 32'h0;
   logic [31:0] model_sum = 32'h0;
   int          rd_cnt = 0, wr_cnt = 0;

   always @(negedge clk) begin
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
   end

   always @(negedge clk) begin
      exp_t        e;
      exp_t        n;
      bit          was_idle;
      logic        erd, ewr, ebusy, edone, eerr;
      logic [31:0] eaddr, ewdata;
      erd = 0; ewr = 0; ebusy = 0; edone = 0; eerr = 0; eaddr = 0; ewdata = 0;
      e.kind = K_IDLE; e.addr = 0; e.busy = 0;
      was_idle = (exp_q.size() == 0);
      if (!was_idle) e = exp_q.pop_front();
      if (reset) begin
         e.kind = K_IDLE;
         exp_q.delete();
      end
      case (e.kind)
         K_READ:  begin erd = 1; eaddr = e.addr; ebusy = 1; end
         K_WRITE: begin ewr = 1; eaddr = e.addr; ewdata = model_buf; ebusy = 1; end
         K_DONE:  begin edone = 1; ebusy = e.busy; end
         K_ERR:   eerr = 1;
         default: ;
      endcase
      check("busy", {31'h0, busy}, {31'h0, ebusy});
      check("done", {31'h0, done}, {31'h0, edone});
      check("err", {31'h0, err}, {31'h0, eerr});
      check("mem_rd", {31'h0, mem_rd}, {31'h0, erd});
      check("mem_wr", {31'h0, mem_wr}, {31'h0, ewr});
      check("mem_addr", mem_addr, eaddr);
      check("mem_wdata", mem_wdata, ewdata);
`ifdef DMA_CHECKSUM_EN
      check("checksum", checksum, reset ? 32'h0 : model_sum);
`endif
      if (e.kind == K_READ) model_buf = refmem[e.addr[9:2]];
      if (e.kind == K_WRITE) begin
         refmem[e.addr[9:2]] = model_buf;
         model_sum = model_sum + model_buf;
      end
      if (reset) model_sum = 32'h0;
      if (was_idle && !reset && start) begin
         n.addr = 0; n.busy = 0;
         if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
            n.kind = K_ERR;
            exp_q.push_back(n);
         end else begin
            model_sum = 32'h0;
            for (int i = 0; i < int'(len); i++) begin
               n.kind = K_READ;  n.addr = src_addr + 32'(4 * i); n.busy = 1; exp_q.push_back(n);
               n.kind = K_WRITE; n.addr = dst_addr + 32'(4 * i); n.busy = 1; exp_q.push_back(n);
            end
            n.kind = K_DONE; n.addr = 0; n.busy = (len != 0);
            exp_q.push_back(n);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      mem[idx]    = val;
      refmem[idx] = val;
   endtask

   // Issue one start in an idle cycle (cycle 0) and follow it to completion.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l,
                           input bit noise, output int done_cyc, output int err_cyc, output bit saw_busy);
      done_cyc = -1; err_cyc = -1; saw_busy = 0;
      src_addr = s; dst_addr = d; len = l; start = 1;
      tick();
      start = 0;
      for (int n = 1; n <= 2 * 256 + 4; n++) begin
         if (busy) saw_busy = 1;
         if (err) err_cyc = n;
         if (done) begin done_cyc = n; break; end
         if (err) break;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
         end
         tick();
      end
      start = 0;
      tick();
   endtask

   function automatic int mem_diffs();
      int d = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) d++;
      return d;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          dc, ec;
      bit          sb;
      logic [31:0] s, d;
      logic [LEN_W-1:0] l;
      reset = 1; start = 0; src_addr = 0; dst_addr = 0; len = 0;
      for (int i = 0; i < 256; i++) poke(i, $urandom);
      repeat (3) @(posedge clk);
      #1 reset = 0;

      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      tick();

      // Basic copy of four words.
      for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
      rd_cnt = 0; wr_cnt = 0;
      run_copy(32'h00, 32'h40, 4, 1, dc, ec, sb);
      check("t1_done_cycle", dc, 9);
      check("t1_rd_count", rd_cnt, 4);
      check("t1_wr_count", wr_cnt, 4);
      for (int i = 0; i < 4; i++) check("t1_dst_word", mem[16 + i], 32'(i + 1));

      // Zero length.
      rd_cnt = 0; wr_cnt = 0;
      run_copy(32'h10, 32'h80, 0, 0, dc, ec, sb);
      check("t2_done_cycle", dc, 1);
      check("t2_busy_seen", {31'h0, sb}, 32'h0);
      check("t2_accesses", rd_cnt + wr_cnt, 0);

      // Misaligned source.
      rd_cnt = 0; wr_cnt = 0;
      run_copy(32'h02, 32'h40, 2, 0, dc, ec, sb);
      check("t3_err_cycle", ec, 1);
      check("t3_done_cycle", dc, -1);
      check("t3_accesses", rd_cnt + wr_cnt, 0);
      repeat (3) tick();

      // Reset during the write of word 2.
      for (int i = 0; i < 4; i++) begin
         poke(i, 32'h11 * (i + 1));
         poke(32 + i, 32'hDEAD_0000 + 32'(i));
      end
      rd_cnt = 0; wr_cnt = 0;
      src_addr = 32'h0; dst_addr = 32'h80; len = 4; start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      reset = 1;
      tick();
      reset = 0;
      check("t4_busy_after", {31'h0, busy}, 32'h0);
      check("t4_wr_after", {31'h0, mem_wr}, 32'h0);
      repeat (3) tick();
      check("t4_word1", mem[32], 32'h11);
      check("t4_word2", mem[33], 32'hDEAD_0001);
      check("t4_wr_count", wr_cnt, 1);

      // Overlapping forward copy propagates the first word.
      poke(0, 32'hA); poke(1, 32'hB); poke(2, 32'hC); poke(3, 32'hD);
      run_copy(32'h00, 32'h04, 3, 1, dc, ec, sb);
      check("t5_done_cycle", dc, 7);
      for (int i = 1; i < 4; i++) check("t5_overlap_word", mem[i], 32'hA);

      // Source address wraps past 2**32.
      poke(254, 32'hA0); poke(255, 32'hA1); poke(0, 32'hA2); poke(1, 32'hA3);
      run_copy(32'hFFFF_FFF8, 32'h100, 4, 1, dc, ec, sb);
      check("wrap_done_cycle", dc, 9);
      check("wrap_word0", mem[64], 32'hA0);
      check("wrap_word3", mem[67], 32'hA3);

`ifdef DMA_CHECKSUM_EN
      poke(0, 32'hFFFF_FFFF); poke(1, 32'h2);
      run_copy(32'h00, 32'h60, 2, 1, dc, ec, sb);
      check("t6_checksum", checksum, 32'h1);
      check("t6_done_cycle", dc, 5);
`endif

      // Randomized copies with start/len noise while busy.
      for (int t = 0; t < 40; t++) begin
         s = {22'h0, 8'($urandom), 2'b00};
         d = {22'h0, 8'($urandom), 2'b00};
         if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
         l = LEN_W'($urandom_range(0, MAXLEN));
         run_copy(s, d, l, 1, dc, ec, sb);
         if (s[1:0] != 0 || d[1:0] != 0) check("rnd_err_cycle", ec, 1);
         else check("rnd_done_cycle", dc, 2 * int'(l) + 1);
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (2) tick();
      check("mem_image", mem_diffs(), 0);
      check("model_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
